// File: rtl/red_pitaya_bus_initiator.sv
// red_pitaya_bus_initiator
//   Queues read/write commands in a small FIFO and replays them one at a
//   time onto the Red Pitaya DSP system bus. Each command produces exactly
//   one response.
//
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o             command handshake (ready = FIFO not full)
//   cmd_we_i, cmd_addr_i, cmd_wdata_i     command payload (we: 1 = write)
//   rsp_valid_o / rsp_ready_i             response handshake
//   rsp_rdata_o, rsp_err_o, rsp_we_o      response payload
//   sys_addr, sys_wdata, sys_sel,
//   sys_wen, sys_ren                      system bus request (one-cycle strobe)
//   sys_rdata, sys_err, sys_ack           system bus reply
//   busy_o                                FSM active or commands queued
//
// Build option:
//   BUS_INITIATOR_TIMEOUT_EN  adds a WAIT-state watchdog that ends the
//                             transaction with an error after TIMEOUT cycles
//                             without sys_ack. Undefined: wait forever.

module red_pitaya_bus_initiator #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // command side
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   // response side
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        rsp_we_o,
   // system bus
   output logic [31:0] sys_addr,
   output logic [31:0] sys_wdata,
   output logic [3:0]  sys_sel,
   output logic        sys_wen,
   output logic        sys_ren,
   input  logic [31:0] sys_rdata,
   input  logic        sys_err,
   input  logic        sys_ack,
   // status
   output logic        busy_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e state_q, state_d;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic          fifo_we_q    [FIFO_DEPTH];
   logic [31:0]   fifo_addr_q  [FIFO_DEPTH];
   logic [31:0]   fifo_wdata_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          head_avail_q;
   logic          fifo_full;
   logic          fifo_push;
   logic          fifo_pop;

   // Full blocks a push even when a pop happens in the same cycle.
   assign fifo_full = (count_q == CW'(FIFO_DEPTH));
   assign fifo_push = cmd_valid_i & ~fifo_full;
   // The FSM pops on a registered "not empty" view, so a freshly written
   // entry is seen one cycle later (strobe lands 2 cycles after accept).
   assign fifo_pop  = (state_q == IDLE) & head_avail_q & (count_q != '0);

   always_ff @(posedge clk_i) begin
      if (fifo_push) begin
         fifo_we_q[wr_ptr_q]    <= cmd_we_i;
         fifo_addr_q[wr_ptr_q]  <= cmd_addr_i;
         fifo_wdata_q[wr_ptr_q] <= cmd_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_avail_q <= 1'b0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         head_avail_q <= (count_q != '0);
      end
   end

   // ------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------
   logic        hold_we_q,    hold_we_d;
   logic [31:0] hold_addr_q,  hold_addr_d;
   logic [31:0] hold_wdata_q, hold_wdata_d;
   logic [31:0] rsp_rdata_q,  rsp_rdata_d;
   logic        rsp_err_q,    rsp_err_d;

`ifdef BUS_INITIATOR_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmo_q, tmo_d;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         hold_we_q    <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         hold_we_q    <= hold_we_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
`ifdef BUS_INITIATOR_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_we_d    = hold_we_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      tmo_d        = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (fifo_pop) begin
               hold_we_d    = fifo_we_q[rd_ptr_q];
               hold_addr_d  = fifo_addr_q[rd_ptr_q];
               hold_wdata_d = fifo_wdata_q[rd_ptr_q];
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // sys_ack is deliberately not looked at here.
            state_d = WAIT;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         WAIT: begin
            if (sys_ack) begin
               rsp_rdata_d = hold_we_q ? '0 : sys_rdata;
               rsp_err_d   = sys_err;
               state_d     = RESP;
            end
`ifdef BUS_INITIATOR_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               // TIMEOUT WAIT cycles elapsed without an ack.
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
`endif
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs (forced to their reset values while rst_i is high)
   // ------------------------------------------------------------------
   logic issuing;
   assign issuing = ~rst_i & (state_q == ISSUE);

   assign cmd_ready_o = rst_i | ~fifo_full;
   assign busy_o      = ~rst_i & ((state_q != IDLE) | (count_q != '0));

   assign sys_wen     = issuing &  hold_we_q;
   assign sys_ren     = issuing & ~hold_we_q;
   assign sys_sel     = issuing ? 4'hF : 4'h0;
   assign sys_addr    = rst_i ? '0 : hold_addr_q;
   assign sys_wdata   = rst_i ? '0 : hold_wdata_q;

   assign rsp_valid_o = ~rst_i & (state_q == RESP);
   assign rsp_rdata_o = rst_i ? '0 : rsp_rdata_q;
   assign rsp_err_o   = ~rst_i & rsp_err_q;
   assign rsp_we_o    = ~rst_i & hold_we_q;

endmodule

// File: tb/tb_red_pitaya_bus_initiator.sv
// tb_red_pitaya_bus_initiator
//   Scoreboard bench: each accepted command pushes its expected bus request
//   and expected response; a monitor pops and compares whenever the DUT
//   strobes the bus or raises rsp_valid_o. A responder model acks strobes
//   according to a per-transaction plan queue.

`timescale 1ns/1ps

module tb_red_pitaya_bus_initiator;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 255;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [31:0] cmd_addr_i, cmd_wdata_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_we_o;
   logic [31:0] rsp_rdata_o;
   logic [31:0] sys_addr, sys_wdata, sys_rdata;
   logic [3:0]  sys_sel;
   logic        sys_wen, sys_ren, sys_err, sys_ack;
   logic        busy_o;

   always #5 clk = ~clk;

   red_pitaya_bus_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
      .sys_wen(sys_wen), .sys_ren(sys_ren),
      .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack),
      .busy_o(busy_o)
   );

   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
   typedef struct packed {logic we; logic err; logic [31:0] rdata;} rsp_t;
   typedef struct packed {logic [7:0] delay; logic [31:0] rdata; logic err;} ack_t;

   req_t exp_req_q[$];
   rsp_t exp_rsp_q[$];
   ack_t ack_plan_q[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   int unsigned strobe_cnt = 0, strobe_cyc = 0;
   int unsigned rise_cnt = 0, rise_cyc = 0;
   int unsigned late_ack_req = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   // ---------------- monitor: strobes and responses ----------------
   initial begin : monitor
      logic prev_strobe = 1'b0;
      logic prev_valid  = 1'b0;
      logic prev_ready  = 1'b0;
      rsp_t prev_rsp    = '0;
      req_t r;
      rsp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sys_wen || sys_ren) begin
            strobe_cnt++;
            strobe_cyc = cyc;
            check1("strobe_one_cycle", prev_strobe, 1'b0);
            check("strobe_sel", {28'd0, sys_sel}, 32'hF);
            if (exp_req_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_strobe: got addr 0x%08h, want no strobe", sys_addr);
            end else begin
               r = exp_req_q.pop_front();
               check1("strobe_wen", sys_wen, r.we);
               check1("strobe_ren", sys_ren, ~r.we);
               check("strobe_addr", sys_addr, r.addr);
               if (r.we) check("strobe_wdata", sys_wdata, r.wdata);
            end
         end
         prev_strobe = sys_wen | sys_ren;

         if (rsp_valid_o && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
            if (exp_rsp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_rsp: got rdata 0x%08h err %b, want no response", rsp_rdata_o, rsp_err_o);
            end else begin
               e = exp_rsp_q.pop_front();
               check1("rsp_we", rsp_we_o, e.we);
               check1("rsp_err", rsp_err_o, e.err);
               check("rsp_rdata", rsp_rdata_o, e.rdata);
            end
         end else if (rsp_valid_o && prev_valid && !prev_ready) begin
            check1("rsp_hold_we", rsp_we_o, prev_rsp.we);
            check1("rsp_hold_err", rsp_err_o, prev_rsp.err);
            check("rsp_hold_rdata", rsp_rdata_o, prev_rsp.rdata);
         end
         prev_valid = rsp_valid_o;
         prev_ready = rsp_ready_i;
         prev_rsp   = {rsp_we_o, rsp_err_o, rsp_rdata_o};
      end
   end

   // ---------------- responder model ----------------
   initial begin : responder
      ack_t        a;
      logic [31:0] addr_at_strobe;
      int unsigned late_done = 0;
      sys_ack = 1'b0; sys_rdata = '0; sys_err = 1'b0;
      forever begin
         @(negedge clk);
         if (late_ack_req != late_done) begin
            late_done = late_ack_req;
            sys_ack = 1'b1; sys_rdata = 32'hBAD0BAD0;
            @(negedge clk);
            sys_ack = 1'b0; sys_rdata = '0;
         end else if ((sys_wen || sys_ren) && ack_plan_q.size() != 0) begin
            a = ack_plan_q.pop_front();
            addr_at_strobe = sys_addr;
            repeat (int'(a.delay)) @(negedge clk);
            if (a.delay != 0) check("addr_stable", sys_addr, addr_at_strobe);
            sys_ack = 1'b1; sys_rdata = a.rdata; sys_err = a.err;
            @(negedge clk);
            sys_ack = 1'b0; sys_rdata = '0; sys_err = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers (called at negedge) ----------------
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_rsp, input logic exp_err, input logic [31:0] exp_rdata,
                       output int unsigned acc_cyc);
      int unsigned budget = 0;
      acc_cyc = 0;
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata;
      while (!cmd_ready_o && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!cmd_ready_o) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got cmd_ready_o 0 for 200 cycles, want 1");
      end else begin
         acc_cyc = cyc + 1;
         exp_req_q.push_back('{we, addr, wdata});
         if (exp_rsp) exp_rsp_q.push_back('{we, exp_err, exp_rdata});
      end
      @(negedge clk);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned budget, input string name);
      int unsigned n = 0;
      while ((busy_o || rsp_valid_o) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy_o || rsp_valid_o) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_idle_timeout: got busy_o %b after %0d cycles, want 0", name, busy_o, budget);
      end
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      #1;
      check1("rst_cmd_ready", cmd_ready_o, 1'b1);
      check1("rst_busy", busy_o, 1'b0);
      check1("rst_rsp_valid", rsp_valid_o, 1'b0);
      check1("rst_strobe", sys_wen | sys_ren, 1'b0);
      check("rst_sys_addr", sys_addr, 32'h0);
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin : stim
      int unsigned acc, s0, r0, n;
      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
      cmd_addr_i = '0; cmd_wdata_i = '0; rsp_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      // reset state
      check1("reset_cmd_ready", cmd_ready_o, 1'b1);
      check1("reset_busy", busy_o, 1'b0);
      check1("reset_rsp_valid", rsp_valid_o, 1'b0);
      check("reset_rsp_rdata", rsp_rdata_o, 32'h0);
      check1("reset_strobe", sys_wen | sys_ren, 1'b0);
      check("reset_sys_sel", {28'd0, sys_sel}, 32'h0);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);

      // single write, ack 1 cycle after strobe
      ack_plan_q.push_back('{8'd1, 32'h0, 1'b0});
      s0 = strobe_cnt;
      send(1'b1, 32'h0004_0000, 32'h5, 1'b1, 1'b0, 32'h0, acc);
      wait_idle(50, "write");
      check("wr_strobe_count", strobe_cnt - s0, 32'd1);
      check("wr_strobe_latency", strobe_cyc - acc, 32'd2);
      check("wr_rsp_latency", rise_cyc - strobe_cyc, 32'd2);

      // single read returning 0x1ABC
      ack_plan_q.push_back('{8'd1, 32'h0000_1ABC, 1'b0});
      send(1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'h0000_1ABC, acc);
      wait_idle(50, "read");
      check("rd_strobe_latency", strobe_cyc - acc, 32'd2);
      check("rd_rsp_latency", rise_cyc - strobe_cyc, 32'd2);

      // bus error, next queued command still issues
      ack_plan_q.push_back('{8'd1, 32'hDEAD_0001, 1'b1});
      ack_plan_q.push_back('{8'd3, 32'h0, 1'b0});
      s0 = strobe_cnt; r0 = rise_cnt;
      send(1'b0, 32'h0000_0020, 32'h0, 1'b1, 1'b1, 32'hDEAD_0001, acc);
      send(1'b1, 32'h0000_0024, 32'h77, 1'b1, 1'b0, 32'h0, acc);
      wait_idle(60, "buserr");
      check("err_strobe_count", strobe_cnt - s0, 32'd2);
      check("err_rsp_count", rise_cnt - r0, 32'd2);

      // FIFO full with responses held off
      rsp_ready_i = 1'b0;
      ack_plan_q.push_back('{8'd1, 32'h0, 1'b0});
      ack_plan_q.push_back('{8'd2, 32'h0000_0011, 1'b0});
      ack_plan_q.push_back('{8'd1, 32'h0, 1'b0});
      ack_plan_q.push_back('{8'd1, 32'h0000_0033, 1'b0});
      ack_plan_q.push_back('{8'd1, 32'h0, 1'b0});
      s0 = strobe_cnt; r0 = rise_cnt;
      send(1'b1, 32'h0000_0100, 32'h1, 1'b1, 1'b0, 32'h0, acc);
      send(1'b0, 32'h0000_0104, 32'h0, 1'b1, 1'b0, 32'h0000_0011, acc);
      send(1'b1, 32'h0000_0108, 32'h3, 1'b1, 1'b0, 32'h0, acc);
      send(1'b0, 32'h0000_010C, 32'h0, 1'b1, 1'b0, 32'h0000_0033, acc);
      send(1'b1, 32'h0000_0110, 32'h5, 1'b1, 1'b0, 32'h0, acc);
      check1("full_cmd_ready", cmd_ready_o, 1'b0);
      repeat (10) @(negedge clk);
      check1("full_cmd_ready_held", cmd_ready_o, 1'b0);
      check("full_one_strobe", strobe_cnt - s0, 32'd1);
      check("full_one_rsp", rise_cnt - r0, 32'd1);
      rsp_ready_i = 1'b1;
      wait_idle(100, "full");
      check("full_drain_strobes", strobe_cnt - s0, 32'd5);
      check("full_drain_rsps", rise_cnt - r0, 32'd5);

      // responder never acks
      r0 = rise_cnt;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      send(1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b1, 32'h0, acc);
      wait_idle(TMO + 50, "timeout");
      check("tmo_rsp_count", rise_cnt - r0, 32'd1);
      check("tmo_latency", rise_cyc - strobe_cyc, TMO + 1);
`else
      send(1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 32'h0, acc);
      repeat (1000) @(negedge clk);
      check("hang_no_rsp", rise_cnt - r0, 32'd0);
      check1("hang_busy", busy_o, 1'b1);
      pulse_reset();
`endif

      // reset while in WAIT, with a stale ack during ISSUE and queued commands
      ack_plan_q.push_back('{8'd0, 32'h1111_1111, 1'b0});
      s0 = strobe_cnt; r0 = rise_cnt;
      send(1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 32'h0, acc);
      n = 0;
      while (strobe_cnt == s0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stale_strobe_seen", strobe_cnt - s0, 32'd1);
      send(1'b1, 32'h0000_0304, 32'hA, 1'b0, 1'b0, 32'h0, acc);
      send(1'b1, 32'h0000_0308, 32'hB, 1'b0, 1'b0, 32'h0, acc);
      repeat (4) @(negedge clk);
      check("stale_ack_ignored", rise_cnt - r0, 32'd0);
      check1("wait_busy", busy_o, 1'b1);
      pulse_reset();
      exp_req_q.delete();
      late_ack_req++;
      repeat (12) @(negedge clk);
      check("late_ack_no_rsp", rise_cnt - r0, 32'd0);
      check("flush_no_strobe", strobe_cnt - s0, 32'd1);
      check1("post_rst_busy", busy_o, 1'b0);
      check1("post_rst_cmd_ready", cmd_ready_o, 1'b1);

      // recovery after reset
      ack_plan_q.push_back('{8'd1, 32'h0, 1'b0});
      send(1'b1, 32'h0004_0004, 32'hA, 1'b1, 1'b0, 32'h0, acc);
      wait_idle(50, "recover");
      check("recover_strobe_latency", strobe_cyc - acc, 32'd2);

      repeat (3) @(negedge clk);
      check("left_exp_req", exp_req_q.size(), 32'd0);
      check("left_exp_rsp", exp_rsp_q.size(), 32'd0);
      check("left_ack_plan", ack_plan_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
